// File: rtl/crp16_alu_pkg.sv
// rtl/crp16_alu_pkg.sv - shared constants for the CRP16 ALU writeback stage
package crp16_alu_pkg;

  localparam int DATA_W = 16;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_CS = 3'd3,
    COND_CC = 3'd4,
    COND_MI = 3'd5,
    COND_GE = 3'd6,
    COND_LT = 3'd7
  } cond_e;

  function automatic int entry_width(input int dest_w);
    return DATA_W + dest_w;
  endfunction

  // COND_AL reads as "never" here: code 0 yields a false condition.
  function automatic logic eval_cond(input logic [2:0] cond, input logic [3:0] f);
    logic res;
    res = 1'b0;
    case (cond)
      COND_AL: res = 1'b0;
      COND_EQ: res = f[FLAG_Z];
      COND_NE: res = ~f[FLAG_Z];
      COND_CS: res = f[FLAG_C];
      COND_CC: res = ~f[FLAG_C];
      COND_MI: res = f[FLAG_N];
      COND_GE: res = (f[FLAG_N] == f[FLAG_V]);
      COND_LT: res = (f[FLAG_N] != f[FLAG_V]);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/crp16_alu_skid.sv
// rtl/crp16_alu_skid.sv - generic 2-entry in-order valid/ready buffer
module crp16_alu_skid #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_push;
  logic             w_pop;

  // in_ready depends only on stored count (and reset), never on out_ready.
  assign in_ready  = reset_n & (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = out_valid ? r_head : '0;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (w_push && w_pop) begin
      // only reachable at count 1: the new entry replaces the departing head
      r_head <= in_data;
    end else if (w_push) begin
      if (r_count == 2'd0) begin
        r_head <= in_data;
      end else begin
        r_tail <= in_data;
      end
      r_count <= r_count + 2'd1;
    end else if (w_pop) begin
      if (r_count == 2'd2) begin
        r_head <= r_tail;
      end
      r_count <= r_count - 2'd1;
    end
  end

endmodule

// File: rtl/crp16_alu_wb.sv
// rtl/crp16_alu_wb.sv - ALU result writeback buffer and flags; CRP16_ALU_COND_EN adds condition evaluation
module crp16_alu_wb
  import crp16_alu_pkg::*;
#(
  parameter int DEST_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       r,
  input  logic              c_out,
  input  logic              v,
  input  logic [DEST_W-1:0] dest,
  input  logic              set_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [3:0]        flags
`ifdef CRP16_ALU_COND_EN
  ,
  input  logic [2:0]        cond,
  output logic              cond_true
`endif
);

  localparam int ENTRY_W = entry_width(DEST_W);

  logic [ENTRY_W-1:0] w_in_entry;
  logic [ENTRY_W-1:0] w_out_entry;
  logic               w_in_ready;
  logic               w_accept;
  logic [3:0]         r_flags;

  assign w_in_entry = {r, dest};
  assign w_accept   = in_valid & w_in_ready;
  assign in_ready   = w_in_ready;

  crp16_alu_skid #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_entry)
  );

  assign out_data = w_out_entry[ENTRY_W-1:DEST_W];
  assign out_dest = w_out_entry[DEST_W-1:0];

  // Flags follow acceptance, not writeback, so they are current for the next op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= 4'b0000;
    end else if (w_accept && set_flags) begin
      r_flags[FLAG_Z] <= (r == 16'h0000);
      r_flags[FLAG_N] <= r[15];
      r_flags[FLAG_C] <= c_out;
      r_flags[FLAG_V] <= v;
    end
  end

  assign flags = r_flags;

`ifdef CRP16_ALU_COND_EN
  assign cond_true = reset_n & eval_cond(cond, r_flags);
`endif

endmodule

// File: tb/tb_crp16_alu_wb.sv
// tb/tb_crp16_alu_wb.sv - self-checking bench for crp16_alu_wb
module tb_crp16_alu_wb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] r;
  logic        c_out;
  logic        v;
  logic [2:0]  dest;
  logic        set_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_dest;
  logic [3:0]  flags;
`ifdef CRP16_ALU_COND_EN
  logic [2:0]  cond;
  logic        cond_true;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  dest;
  } sb_t;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        sf;
    logic [3:0]  exp_flags;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[8];

  crp16_alu_wb #(.DEST_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r         (r),
    .c_out     (c_out),
    .v         (v),
    .dest      (dest),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .flags     (flags)
`ifdef CRP16_ALU_COND_EN
    ,
    .cond      (cond),
    .cond_true (cond_true)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshakes are sampled mid-cycle; they complete on the following rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got %0h expected none", out_data);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("wb_data", {16'h0, out_data}, {16'h0, e.data});
          check("wb_dest", {29'h0, out_dest}, {29'h0, e.dest});
        end
      end
      if (in_valid && in_ready) sb_q.push_back({r, dest});
    end
  end

  task automatic drive(input logic [15:0] rv, input logic c, input logic vv,
                       input logic [2:0] d, input logic sf);
    in_valid  = 1'b1;
    r         = rv;
    c_out     = c;
    v         = vv;
    dest      = d;
    set_flags = sf;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    set_flags = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin
      step();
      n++;
    end
    check("drain_timeout", {31'h0, out_valid}, 32'h0);
    check("empty_data", {16'h0, out_data}, 32'h0);
    check("empty_dest", {29'h0, out_dest}, 32'h0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0000, 1'b1, 1'b0, 1'b1, 4'b1010};
    vecs[1] = '{16'h8001, 1'b0, 1'b0, 1'b1, 4'b0100};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[3] = '{16'h7FFF, 1'b0, 1'b1, 1'b1, 4'b0001};
    vecs[4] = '{16'h8000, 1'b1, 1'b1, 1'b1, 4'b0111};
    vecs[5] = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'b1000};
    vecs[6] = '{16'h1234, 1'b1, 1'b0, 1'b0, 4'b1000};
    vecs[7] = '{16'h0001, 1'b1, 1'b0, 1'b1, 4'b0010};

    reset_n   = 1'b0;
    out_ready = 1'b0;
    r         = 16'h0;
    c_out     = 1'b0;
    v         = 1'b0;
    dest      = 3'h0;
    idle();
`ifdef CRP16_ALU_COND_EN
    cond = 3'd2;
`endif
    #2;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_flags", {28'h0, flags}, 32'h0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
`ifdef CRP16_ALU_COND_EN
    check("rst_cond_true", {31'h0, cond_true}, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", {31'h0, in_ready}, 32'h1);
    check("rel_out_valid", {31'h0, out_valid}, 32'h0);

    // zero result with carry: one-cycle latency and Z/C flags
    step();
    drive(16'h0000, 1'b1, 1'b0, 3'd5, 1'b1);
    step();
    idle();
    check("lat_out_valid", {31'h0, out_valid}, 32'h1);
    check("lat_out_data", {16'h0, out_data}, 32'h0);
    check("lat_out_dest", {29'h0, out_dest}, 32'h5);
    check("lat_flags", {28'h0, flags}, 32'hA);
    drain();

    // fill with out_ready low, third push must be ignored
    drive(16'h8001, 1'b0, 1'b0, 3'd1, 1'b1);
    step();
    drive(16'h0005, 1'b0, 1'b0, 3'd2, 1'b0);
    step();
    check("full_in_ready", {31'h0, in_ready}, 32'h0);
    drive(16'h1234, 1'b1, 1'b1, 3'd3, 1'b1);
    step();
    step();
    idle();
    check("full_flags_hold", {28'h0, flags}, 32'h4);
    check("full_head", {16'h0, out_data}, 32'h8001);
    out_ready = 1'b1;
    step();
    check("pop2_in_ready", {31'h0, in_ready}, 32'h1);
    check("pop2_head", {16'h0, out_data}, 32'h0005);
    drain();

    // simultaneous push and pop at count 1
    drive(16'h0003, 1'b0, 1'b0, 3'd3, 1'b0);
    step();
    drive(16'h0007, 1'b0, 1'b0, 3'd4, 1'b0);
    out_ready = 1'b1;
    step();
    idle();
    out_ready = 1'b0;
    check("pp_out_valid", {31'h0, out_valid}, 32'h1);
    check("pp_out_data", {16'h0, out_data}, 32'h0007);
    check("pp_in_ready", {31'h0, in_ready}, 32'h1);
    drain();

    // set_flags=0 leaves prior flags
    drive(16'h0000, 1'b1, 1'b0, 3'd0, 1'b1);
    step();
    drive(16'hFFFF, 1'b1, 1'b1, 3'd6, 1'b0);
    step();
    idle();
    check("nosf_flags", {28'h0, flags}, 32'hA);
    drain();

    // back-to-back table with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tbl_in_ready", {31'h0, in_ready}, 32'h1);
      drive(vecs[i].r, vecs[i].c, vecs[i].v, i[2:0], vecs[i].sf);
      step();
      check($sformatf("tbl_flags_%0d", i), {28'h0, flags}, {28'h0, vecs[i].exp_flags});
    end
    idle();
    drain();

`ifdef CRP16_ALU_COND_EN
    drive(16'h8000, 1'b0, 1'b0, 3'd0, 1'b1);
    step();
    idle();
    cond = 3'd6;
    #1;
    check("cond_ge", {31'h0, cond_true}, 32'h0);
    cond = 3'd7;
    #1;
    check("cond_lt", {31'h0, cond_true}, 32'h1);
    cond = 3'd5;
    #1;
    check("cond_mi", {31'h0, cond_true}, 32'h1);
    cond = 3'd1;
    #1;
    check("cond_eq", {31'h0, cond_true}, 32'h0);
    cond = 3'd2;
    drain();
`endif

    // asynchronous reset with two entries held
    out_ready = 1'b0;
    drive(16'h8001, 1'b0, 1'b1, 3'd1, 1'b1);
    step();
    drive(16'h0042, 1'b0, 1'b0, 3'd2, 1'b0);
    step();
    idle();
    check("pre_rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("pre_rst_flags", {28'h0, flags}, 32'h5);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", {31'h0, out_valid}, 32'h0);
    check("arst_flags", {28'h0, flags}, 32'h0);
    check("arst_in_ready", {31'h0, in_ready}, 32'h0);
    check("arst_out_data", {16'h0, out_data}, 32'h0);
    check("arst_out_dest", {29'h0, out_dest}, 32'h0);
`ifdef CRP16_ALU_COND_EN
    check("arst_cond_true", {31'h0, cond_true}, 32'h0);
`endif
    sb_q.delete();
    step();
    reset_n = 1'b1;
    #1;
    check("arel_in_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    step();
    check("arel_out_valid", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;

    check("scoreboard_empty", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
